piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_pkg.sv | 23 ++
 rtl/piso_shreg.sv | 64 ++++++
 rtl/piso_tx.sv | 141 ++++++++++++++
 tb/tb_piso_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter.
// The PARITY state exists only when PISO_TX_PARITY_EN is defined.
package piso_pkg;

   localparam int PISO_MAX_WIDTH = 32;
   localparam int PISO_MAX_GAP   = 15;

`ifdef PISO_TX_PARITY_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2,
      ST_GAP    = 2'd3
   } piso_state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd3
   } piso_state_t;
`endif

endpackage

// File: rtl/piso_shreg.sv
// Loadable shift register with selectable shift direction.
// Vacated positions fill with zeros, so once a word has been fully shifted
// out the head bit reads 0 until the next load.
module piso_shreg #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data_in,
   output logic             serial_bit
);

   logic [WIDTH-1:0] shreg_reg;
   logic [WIDTH-1:0] shreg_next;
   logic [WIDTH-1:0] shifted;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         if (MSB_FIRST != 0) begin : g_msb
            if (gi == 0) begin : g_fill
               assign shifted[gi] = 1'b0;
            end else begin : g_move
               assign shifted[gi] = shreg_reg[gi-1];
            end
         end else begin : g_lsb
            if (gi == WIDTH-1) begin : g_fill
               assign shifted[gi] = 1'b0;
            end else begin : g_move
               assign shifted[gi] = shreg_reg[gi+1];
            end
         end
      end

      if (MSB_FIRST != 0) begin : g_head_msb
         assign serial_bit = shreg_reg[WIDTH-1];
      end else begin : g_head_lsb
         assign serial_bit = shreg_reg[0];
      end
   endgenerate

   // Load has priority over shift so a new word can follow the last bit directly.
   always_comb begin
      shreg_next = shreg_reg;
      if (load) begin
         shreg_next = data_in;
      end else if (shift) begin
         shreg_next = shifted;
      end
   end

   // Register the shift contents; reset clears any word in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         shreg_reg <= '0;
      end else begin
         shreg_reg <= shreg_next;
      end
   end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with valid/ready load handshake.
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit
// after the data bits of every frame.
module piso_tx #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   parameter int GAP       = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             done
);

   import piso_pkg::*;

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
   localparam logic [3:0]       GAP_LOAD = 4'((GAP > 0) ? GAP - 1 : 0);

   piso_state_t      state_reg;
   piso_state_t      state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic [3:0]       gap_cnt_reg;
   logic [3:0]       gap_cnt_next;
   logic             shift_bit;
   logic             accept;
   logic             frame_end;
`ifdef PISO_TX_PARITY_EN
   logic             parity_reg;
   logic             parity_next;
`endif

   piso_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clock      (clock),
      .reset      (reset),
      .load       (accept),
      .shift      (state_reg == ST_SHIFT),
      .data_in    (data_in),
      .serial_bit (shift_bit)
   );

   // Handshake, next-state and counter updates; an accept on the final
   // frame bit (GAP=0) restarts SHIFT without passing through IDLE.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      gap_cnt_next = gap_cnt_reg;
`ifdef PISO_TX_PARITY_EN
      parity_next  = parity_reg;
      frame_end    = (state_reg == ST_PARITY);
`else
      frame_end    = (state_reg == ST_SHIFT) && (cnt_reg == '0);
`endif
      load_ready   = (state_reg == ST_IDLE) || ((GAP == 0) && frame_end);
      accept       = load_valid && load_ready;

      case (state_reg)
         ST_IDLE: begin
            state_next = ST_IDLE;
         end
         ST_SHIFT: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else begin
`ifdef PISO_TX_PARITY_EN
               state_next   = ST_PARITY;
`else
               state_next   = (GAP > 0) ? ST_GAP : ST_IDLE;
               gap_cnt_next = GAP_LOAD;
`endif
            end
         end
`ifdef PISO_TX_PARITY_EN
         ST_PARITY: begin
            state_next   = (GAP > 0) ? ST_GAP : ST_IDLE;
            gap_cnt_next = GAP_LOAD;
         end
`endif
         ST_GAP: begin
            if (gap_cnt_reg == '0) begin
               state_next = ST_IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg - 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (accept) begin
         state_next = ST_SHIFT;
         cnt_next   = CNT_LOAD;
`ifdef PISO_TX_PARITY_EN
         parity_next = ^data_in;
`endif
      end
   end

   // State, bit counter, gap counter and parity registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         gap_cnt_reg <= '0;
`ifdef PISO_TX_PARITY_EN
         parity_reg  <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         gap_cnt_reg <= gap_cnt_next;
`ifdef PISO_TX_PARITY_EN
         parity_reg  <= parity_next;
`endif
      end
   end

   // Serial outputs come straight from registers; the shift register is
   // all zeros outside a data phase, so serial_out is 0 whenever idle.
   always_comb begin
`ifdef PISO_TX_PARITY_EN
      serial_valid = (state_reg == ST_SHIFT) || (state_reg == ST_PARITY);
      serial_out   = (state_reg == ST_PARITY) ? parity_reg : shift_bit;
`else
      serial_valid = (state_reg == ST_SHIFT);
      serial_out   = shift_bit;
`endif
      done = frame_end;
   end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: three instances (MSB-first, LSB-first,
// MSB-first with GAP=3) share one clock and reset.
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FL = 8 + PAR;

   typedef struct packed {
      logic b;
      logic d;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] din [3];
   logic       lv  [3];
   logic       rdy [3];
   logic       so  [3];
   logic       sv  [3];
   logic       dn  [3];

   exp_t sbq[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clock = ~clock;

   piso_tx #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) u_msb (
      .clock(clock), .reset(reset), .data_in(din[0]), .load_valid(lv[0]),
      .load_ready(rdy[0]), .serial_out(so[0]), .serial_valid(sv[0]), .done(dn[0]));

   piso_tx #(.WIDTH(8), .MSB_FIRST(0), .GAP(0)) u_lsb (
      .clock(clock), .reset(reset), .data_in(din[1]), .load_valid(lv[1]),
      .load_ready(rdy[1]), .serial_out(so[1]), .serial_valid(sv[1]), .done(dn[1]));

   piso_tx #(.WIDTH(8), .MSB_FIRST(1), .GAP(3)) u_gap (
      .clock(clock), .reset(reset), .data_in(din[2]), .load_valid(lv[2]),
      .load_ready(rdy[2]), .serial_out(so[2]), .serial_valid(sv[2]), .done(dn[2]));

   // Expected frame of one accepted word, in transmit order.
   task automatic push_word(input int k, input logic [7:0] w);
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         e.b = (k == 1) ? w[i] : w[7-i];
         e.d = (i == 7) && (PAR == 0);
         sbq.push_back(e);
      end
      if (PAR != 0) begin
         e.b = ^w;
         e.d = 1'b1;
         sbq.push_back(e);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         lv[k]  = 1'b0;
         din[k] = 8'h00;
      end
      @(negedge clock);
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (sv[k] !== 1'b0 || so[k] !== 1'b0 || dn[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: sv=%b so=%b done=%b, required all 0", k, sv[k], so[k], dn[k]);
         end
      end
      reset = 1'b0;
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (rdy[k] !== 1'b1 || sv[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_reset dut%0d: rdy=%b sv=%b, required rdy=1 sv=0", k, rdy[k], sv[k]);
         end
      end
   endtask

   // GAP=0 instances: words are offered with load_valid held high; while the
   // block is busy a junk word is presented and must be ignored.
   task automatic test_frames(input int k, input int nw, input logic [7:0] w0,
                              input logic [7:0] w1, input string tag);
      exp_t e;
      logic exp_rdy;
      int   idx;
      int   ncyc;
      idx  = 0;
      ncyc = nw * FL + 3;
      for (int c = 0; c < ncyc; c++) begin
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_cmp++;
            if (sv[k] !== 1'b1 || so[k] !== e.b || dn[k] !== e.d || rdy[k] !== e.d) begin
               n_fail++;
               $display("FAIL %s cyc%0d: sv=%b so=%b done=%b rdy=%b, required sv=1 so=%b done=%b rdy=%b",
                        tag, c, sv[k], so[k], dn[k], rdy[k], e.b, e.d, e.d);
            end
            exp_rdy = e.d;
         end else begin
            n_cmp++;
            if (sv[k] !== 1'b0 || so[k] !== 1'b0 || dn[k] !== 1'b0 || rdy[k] !== 1'b1) begin
               n_fail++;
               $display("FAIL %s idle cyc%0d: sv=%b so=%b done=%b rdy=%b, required sv=0 so=0 done=0 rdy=1",
                        tag, c, sv[k], so[k], dn[k], rdy[k]);
            end
            exp_rdy = 1'b1;
         end
         if (idx < nw && exp_rdy) begin
            din[k] = (idx == 0) ? w0 : w1;
            lv[k]  = 1'b1;
            push_word(k, din[k]);
            idx++;
         end else if (idx < nw) begin
            din[k] = 8'h5A;
            lv[k]  = 1'b1;
         end else begin
            din[k] = 8'h5A;
            lv[k]  = 1'b0;
         end
         @(negedge clock);
      end
      lv[k] = 1'b0;
      n_cmp++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL %s drain: %0d bits outstanding, required 0", tag, sbq.size());
      end
      sbq.delete();
   endtask

   // GAP=3 instance: ready low through the frame and the 3 gap cycles,
   // high again in the following IDLE cycle where the next word is taken.
   task automatic test_gap();
      exp_t e;
      int   idx;
      int   gap_left;
      logic can_push;
      idx      = 0;
      gap_left = 0;
      for (int c = 0; c < 2 * (FL + 4) + 3; c++) begin
         can_push = 1'b0;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_cmp++;
            if (sv[2] !== 1'b1 || so[2] !== e.b || dn[2] !== e.d || rdy[2] !== 1'b0) begin
               n_fail++;
               $display("FAIL gap_frame cyc%0d: sv=%b so=%b done=%b rdy=%b, required sv=1 so=%b done=%b rdy=0",
                        c, sv[2], so[2], dn[2], rdy[2], e.b, e.d);
            end
            if (e.d) gap_left = 3;
         end else if (gap_left > 0) begin
            n_cmp++;
            if (sv[2] !== 1'b0 || so[2] !== 1'b0 || dn[2] !== 1'b0 || rdy[2] !== 1'b0) begin
               n_fail++;
               $display("FAIL gap_idle cyc%0d: sv=%b so=%b done=%b rdy=%b, required sv=0 so=0 done=0 rdy=0",
                        c, sv[2], so[2], dn[2], rdy[2]);
            end
            gap_left--;
         end else begin
            n_cmp++;
            if (sv[2] !== 1'b0 || so[2] !== 1'b0 || rdy[2] !== 1'b1) begin
               n_fail++;
               $display("FAIL gap_ready cyc%0d: sv=%b so=%b rdy=%b, required sv=0 so=0 rdy=1",
                        c, sv[2], so[2], rdy[2]);
            end
            can_push = 1'b1;
         end
         if (idx < 2 && can_push) begin
            din[2] = (idx == 0) ? 8'hA5 : 8'h3C;
            lv[2]  = 1'b1;
            push_word(2, din[2]);
            idx++;
         end else begin
            din[2] = 8'hC3;
            lv[2]  = (idx < 2);
         end
         @(negedge clock);
      end
      lv[2] = 1'b0;
      n_cmp++;
      if (sbq.size() != 0 || idx != 2) begin
         n_fail++;
         $display("FAIL gap_drain: %0d bits outstanding, %0d words taken, required 0 and 2", sbq.size(), idx);
      end
      sbq.delete();
   endtask

   // Reset on data bit 4 of 0xA5 drops the frame; reset also beats an accept.
   task automatic test_reset_midframe();
      exp_t e;
      n_cmp++;
      if (rdy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_start: rdy=%b, required 1", rdy[0]);
      end
      din[0] = 8'hA5;
      lv[0]  = 1'b1;
      push_word(0, 8'hA5);
      @(negedge clock);
      lv[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         e = sbq.pop_front();
         n_cmp++;
         if (sv[0] !== 1'b1 || so[0] !== e.b || dn[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_bit%0d: sv=%b so=%b done=%b, required sv=1 so=%b done=0",
                     i + 1, sv[0], so[0], dn[0], e.b);
         end
         if (i < 3) @(negedge clock);
      end
      sbq.delete();
      reset = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (sv[0] !== 1'b0 || so[0] !== 1'b0 || dn[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_drop: sv=%b so=%b done=%b, required all 0", sv[0], so[0], dn[0]);
      end
      din[0] = 8'hFF;
      lv[0]  = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      lv[0] = 1'b0;
      n_cmp++;
      if (sv[0] !== 1'b0 || rdy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_beats_accept: sv=%b rdy=%b, required sv=0 rdy=1", sv[0], rdy[0]);
      end
      @(negedge clock);
      n_cmp++;
      if (sv[0] !== 1'b0 || so[0] !== 1'b0 || rdy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_release: sv=%b so=%b rdy=%b, required sv=0 so=0 rdy=1", sv[0], so[0], rdy[0]);
      end
      test_frames(0, 1, 8'h3C, 8'h00, "after_reset_3c");
   endtask

   initial begin
      test_reset();
      $display("test msb_first 0xA5");
      test_frames(0, 1, 8'hA5, 8'h00, "msb_a5");
      $display("test lsb_first 0xA5 and 0x01");
      test_frames(1, 1, 8'hA5, 8'h00, "lsb_a5");
      test_frames(1, 1, 8'h01, 8'h00, "lsb_01");
      $display("test back_to_back 0xFF then 0x00");
      test_frames(0, 2, 8'hFF, 8'h00, "b2b_ff_00");
      test_frames(1, 2, 8'h07, 8'hA5, "b2b_lsb_07_a5");
      $display("test gap=3");
      test_gap();
      $display("test reset during frame");
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
